// File: rtl/error_diffusion_ditherer.sv
// Floyd-Steinberg error-diffusion ditherer: 8-bit grayscale raster in, 1-bit dithered stream out.
// The quantisation threshold is captured on pixel (0,0) and held for the whole frame.
module error_diffusion_ditherer #(
    parameter int H_PIXELS = 320,
    parameter int V_PIXELS = 240
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] pixel_in,
    input  logic       pixel_valid_in,
    input  logic [7:0] threshold_in,
    output logic       dithered_pixel,
    output logic       dithered_valid,
    output logic [7:0] threshold_active_out,
    output logic       frame_done_out
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

    logic [XW-1:0]      x_q, x_d, x_prev;
    logic [YW-1:0]      y_q, y_d;
    logic [7:0]         thr_q, thr_d, thr_eff;
    logic signed [9:0]  err_right_q, err_right_d;
    logic signed [9:0]  acc_prev_q, acc_prev_d;
    logic signed [9:0]  acc_cur_q, acc_cur_d;
    logic signed [9:0]  line_buf [H_PIXELS];
    logic signed [9:0]  below, right, w7, w5, w3, w1, wr_prev;
    logic signed [11:0] v, e;
    logic [7:0]         vs;
    logic               q_bit, first_px, last_px, last_row;
    logic               dpix_q, dval_q, fdone_q;

    // acc_prev holds the next-row error for x-1 (complete once the k=3 term of pixel x
    // is added); acc_cur holds the k=1 term already aimed at position x.
    always_comb begin
        first_px = (x_q == '0) && (y_q == '0);
        last_px  = (x_q == X_LAST);
        last_row = (y_q == Y_LAST);
        x_prev   = x_q - XW'(1);
        thr_eff  = first_px ? threshold_in : thr_q;
        below    = (y_q == '0) ? '0 : line_buf[x_q];
        right    = (x_q == '0) ? '0 : err_right_q;

        v = $signed({4'b0000, pixel_in})
          + $signed({{2{below[9]}}, below})
          + $signed({{2{right[9]}}, right});
        if (v < 0)
            vs = '0;
        else if (v > 12'sd255)
            vs = '1;
        else
            vs = v[7:0];

        q_bit = (vs >= thr_eff);
        e     = $signed({4'b0000, vs}) - (q_bit ? 12'sd255 : 12'sd0);
        w7    = 10'((e * 12'sd7) >>> 4);
        w5    = 10'((e * 12'sd5) >>> 4);
        w3    = 10'((e * 12'sd3) >>> 4);
        w1    = 10'(e >>> 4);

        wr_prev     = acc_prev_q + w3;
        acc_prev_d  = ((x_q == '0) ? 10'sd0 : acc_cur_q) + w5;
        acc_cur_d   = w1;
        err_right_d = w7;
        thr_d       = thr_eff;

        x_d = last_px ? '0 : x_q + XW'(1);
        y_d = y_q;
        if (last_px)
            y_d = last_row ? '0 : y_q + YW'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_q         <= '0;
            y_q         <= '0;
            thr_q       <= '0;
            err_right_q <= '0;
            acc_prev_q  <= '0;
            acc_cur_q   <= '0;
            dpix_q      <= 1'b0;
            dval_q      <= 1'b0;
            fdone_q     <= 1'b0;
        end else begin
            dval_q  <= pixel_valid_in;
            dpix_q  <= pixel_valid_in & q_bit;
            fdone_q <= pixel_valid_in & last_px & last_row;
            if (pixel_valid_in) begin
                x_q         <= x_d;
                y_q         <= y_d;
                thr_q       <= thr_d;
                err_right_q <= err_right_d;
                acc_prev_q  <= acc_prev_d;
                acc_cur_q   <= acc_cur_d;
            end
        end
    end

    // Every entry is rewritten during each non-final row, so row 0 simply ignores stale data.
    always_ff @(posedge clk_in) begin
        if (pixel_valid_in && !last_row) begin
            if (x_q != '0)
                line_buf[x_prev] <= wr_prev;
            if (last_px)
                line_buf[x_q] <= acc_prev_d;
        end
    end

    assign dithered_pixel       = dpix_q;
    assign dithered_valid       = dval_q;
    assign frame_done_out       = fdone_q;
    assign threshold_active_out = thr_q;

endmodule

// File: tb/tb_error_diffusion_ditherer.sv
// Directed bench for error_diffusion_ditherer on a reduced 8x4 frame.
// A plain 2-D Floyd-Steinberg reference provides per-pixel expectations.
module tb_error_diffusion_ditherer;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] pixel_in;
    logic       pixel_valid_in;
    logic [7:0] threshold_in;
    logic       dithered_pixel;
    logic       dithered_valid;
    logic [7:0] threshold_active_out;
    logic       frame_done_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   pix  [N];
    logic expb [N];
    logic got  [N];
    logic gota [N];
    logic fdg  [N];
    int   lat_err, tao_err, fd_count, strobes;

    always #5 clk_in = ~clk_in;

    error_diffusion_ditherer #(
        .H_PIXELS(H),
        .V_PIXELS(V)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .pixel_in            (pixel_in),
        .pixel_valid_in      (pixel_valid_in),
        .threshold_in        (threshold_in),
        .dithered_pixel      (dithered_pixel),
        .dithered_valid      (dithered_valid),
        .threshold_active_out(threshold_active_out),
        .frame_done_out      (frame_done_out)
    );

    task automatic step(input logic vld, input logic [7:0] p, input logic [7:0] t);
        pixel_valid_in = vld;
        pixel_in       = p;
        threshold_in   = t;
        @(negedge clk_in);
    endtask

    function automatic void model(input int thr);
        int err [V][H];
        int vv, vs, o, e;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                err[y][x] = 0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                vv = pix[y*H + x] + err[y][x];
                vs = (vv < 0) ? 0 : ((vv > 255) ? 255 : vv);
                o  = (vs >= thr) ? 1 : 0;
                e  = vs - (o ? 255 : 0);
                expb[y*H + x] = o[0];
                if (x + 1 < H) err[y][x+1] += (e * 7) >>> 4;
                if (y + 1 < V) begin
                    if (x > 0) err[y+1][x-1] += (e * 3) >>> 4;
                    err[y+1][x] += (e * 5) >>> 4;
                    if (x + 1 < H) err[y+1][x+1] += e >>> 4;
                end
            end
        end
    endfunction

    function automatic void fill(input int k);
        for (int i = 0; i < N; i++)
            pix[i] = (i * 37 + k * 53 + 11) % 256;
    endfunction

    task automatic run_frame(input bit gaps, input int t0, input int t1, input int chg,
                             input int tao_exp);
        int ng;
        lat_err = 0; tao_err = 0; fd_count = 0; strobes = 0;
        for (int i = 0; i < N; i++) begin
            ng = gaps ? $urandom_range(0, 3) : 0;
            for (int k = 0; k < ng; k++) begin
                step(1'b0, 8'hAA, 8'((i >= chg) ? t1 : t0));
                if (dithered_valid !== 1'b0) lat_err++;
                if (frame_done_out === 1'b1) fd_count++;
            end
            step(1'b1, 8'(pix[i]), 8'((i >= chg) ? t1 : t0));
            if (dithered_valid !== 1'b1) lat_err++;
            else strobes++;
            got[i] = dithered_pixel;
            fdg[i] = frame_done_out;
            if (frame_done_out === 1'b1) fd_count++;
            if (threshold_active_out !== 8'(tao_exp)) tao_err++;
        end
        step(1'b0, 8'h00, 8'(t1));
        if (dithered_valid !== 1'b0) lat_err++;
        if (frame_done_out === 1'b1) fd_count++;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        step(1'b1, 8'hFF, 8'd50);
        step(1'b1, 8'hFF, 8'd50);
        n_cmp++; if (dithered_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", dithered_valid); end
        n_cmp++; if (dithered_pixel !== 1'b0) begin n_bad++; $display("FAIL reset_pixel: got %b expected 0", dithered_pixel); end
        n_cmp++; if (frame_done_out !== 1'b0) begin n_bad++; $display("FAIL reset_fdone: got %b expected 0", frame_done_out); end
        n_cmp++; if (threshold_active_out !== 8'd0) begin n_bad++; $display("FAIL reset_thr: got %0d expected 0", threshold_active_out); end
        pixel_valid_in = 1'b0;
        rst_in = 1'b1;
        step(1'b0, 8'h00, 8'd0);
    endtask

    task automatic test_all_black();
        for (int i = 0; i < N; i++) pix[i] = 0;
        run_frame(1'b0, 128, 128, N, 128);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (got[i] !== 1'b0) begin n_bad++; $display("FAIL black_pix[%0d]: got %b expected 0", i, got[i]); end
        end
        n_cmp++; if (strobes !== N) begin n_bad++; $display("FAIL black_strobes: got %0d expected %0d", strobes, N); end
        n_cmp++; if (lat_err !== 0) begin n_bad++; $display("FAIL black_latency: got %0d errors expected 0", lat_err); end
        n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL black_fdone_count: got %0d expected 1", fd_count); end
        n_cmp++; if (fdg[N-1] !== 1'b1) begin n_bad++; $display("FAIL black_fdone_last: got %b expected 1", fdg[N-1]); end
        n_cmp++; if (tao_err !== 0) begin n_bad++; $display("FAIL black_thr_active: got %0d errors expected 0", tao_err); end
    endtask

    task automatic test_all_white();
        for (int i = 0; i < N; i++) pix[i] = 255;
        run_frame(1'b0, 128, 128, N, 128);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (got[i] !== 1'b1) begin n_bad++; $display("FAIL white_pix[%0d]: got %b expected 1", i, got[i]); end
        end
        n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL white_fdone_count: got %0d expected 1", fd_count); end
    endtask

    task automatic test_row100();
        logic [7:0] row0;
        row0 = 8'b1001_0010;
        for (int i = 0; i < N; i++) pix[i] = 100;
        model(128);
        run_frame(1'b0, 128, 128, N, 128);
        for (int x = 0; x < H; x++) begin
            n_cmp++; if (got[x] !== row0[x]) begin n_bad++; $display("FAIL row100_hand[%0d]: got %b expected %b", x, got[x], row0[x]); end
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (got[i] !== expb[i]) begin n_bad++; $display("FAIL row100_model[%0d]: got %b expected %b", i, got[i], expb[i]); end
        end
    endtask

    task automatic test_threshold_latch();
        fill(1);
        model(128);
        run_frame(1'b0, 128, 0, 10, 128);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (got[i] !== expb[i]) begin n_bad++; $display("FAIL thr_hold_pix[%0d]: got %b expected %b", i, got[i], expb[i]); end
        end
        n_cmp++; if (tao_err !== 0) begin n_bad++; $display("FAIL thr_hold_active: got %0d errors expected 0", tao_err); end
        n_cmp++; if (threshold_active_out !== 8'd128) begin n_bad++; $display("FAIL thr_before_relatch: got %0d expected 128", threshold_active_out); end
        model(0);
        run_frame(1'b0, 0, 0, N, 0);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (got[i] !== expb[i]) begin n_bad++; $display("FAIL thr_zero_pix[%0d]: got %b expected %b", i, got[i], expb[i]); end
        end
        n_cmp++; if (tao_err !== 0) begin n_bad++; $display("FAIL thr_zero_active: got %0d errors expected 0", tao_err); end
    endtask

    task automatic test_stalls();
        fill(2);
        model(90);
        run_frame(1'b0, 90, 90, N, 90);
        for (int i = 0; i < N; i++) gota[i] = got[i];
        run_frame(1'b1, 90, 90, N, 90);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (got[i] !== gota[i]) begin n_bad++; $display("FAIL stall_vs_b2b[%0d]: got %b expected %b", i, got[i], gota[i]); end
            n_cmp++; if (got[i] !== expb[i]) begin n_bad++; $display("FAIL stall_model[%0d]: got %b expected %b", i, got[i], expb[i]); end
        end
        n_cmp++; if (lat_err !== 0) begin n_bad++; $display("FAIL stall_latency: got %0d errors expected 0", lat_err); end
        n_cmp++; if (strobes !== N) begin n_bad++; $display("FAIL stall_strobes: got %0d expected %0d", strobes, N); end
        n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL stall_fdone_count: got %0d expected 1", fd_count); end
    endtask

    task automatic test_reset_midrow();
        fill(3);
        for (int i = 0; i <= 2*H + 5; i++)
            step(1'b1, 8'(pix[i]), 8'd128);
        n_cmp++; if (dithered_valid !== 1'b1) begin n_bad++; $display("FAIL midrow_pre_valid: got %b expected 1", dithered_valid); end
        n_cmp++; if (threshold_active_out !== 8'd128) begin n_bad++; $display("FAIL midrow_pre_thr: got %0d expected 128", threshold_active_out); end
        #2 rst_in = 1'b0;
        #1;
        n_cmp++; if (dithered_valid !== 1'b0) begin n_bad++; $display("FAIL midrow_async_valid: got %b expected 0", dithered_valid); end
        n_cmp++; if (dithered_pixel !== 1'b0) begin n_bad++; $display("FAIL midrow_async_pixel: got %b expected 0", dithered_pixel); end
        n_cmp++; if (threshold_active_out !== 8'd0) begin n_bad++; $display("FAIL midrow_async_thr: got %0d expected 0", threshold_active_out); end
        pixel_valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        fill(4);
        model(200);
        run_frame(1'b0, 200, 200, N, 200);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (got[i] !== expb[i]) begin n_bad++; $display("FAIL post_reset_pix[%0d]: got %b expected %b", i, got[i], expb[i]); end
        end
        n_cmp++; if (tao_err !== 0) begin n_bad++; $display("FAIL post_reset_thr: got %0d errors expected 0", tao_err); end
        n_cmp++; if (fdg[N-1] !== 1'b1) begin n_bad++; $display("FAIL post_reset_fdone: got %b expected 1", fdg[N-1]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in         = 1'b0;
        pixel_valid_in = 1'b0;
        pixel_in       = 8'd0;
        threshold_in   = 8'd0;
        @(negedge clk_in);
        test_reset();
        test_all_black();
        test_all_white();
        test_row100();
        test_threshold_latch();
        test_stalls();
        test_reset_midrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/error_diffusion_ditherer.md
Name: error_diffusion_ditherer

Overview:
Converts the 8-bit grayscale camera pixel stream into the 1-bit dithered stream consumed by threshold_calibrator and the GIF frame path. Uses Floyd-Steinberg error diffusion with a programmable quantisation threshold, normally driven by threshold_calibrator.threshold_out. It sits between the grayscale converter and every consumer of dithered_pixel/dithered_valid. The threshold is latched once per frame, so a calibrator sweep never tears a frame.

Parameters:
H_PIXELS, 320, active pixels per line
V_PIXELS, 240, lines per frame

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
pixel_in  input  8  grayscale pixel, raster order
pixel_valid_in  input  1  pixel_in valid this cycle; may deassert arbitrarily (stall)
threshold_in  input  8  quantisation threshold
dithered_pixel  output  1  dithered bit, 1 = white
dithered_valid  output  1  one-cycle strobe per dithered pixel
threshold_active_out  output  8  threshold in use for the current frame
frame_done_out  output  1  one-cycle pulse with the last pixel of a frame

Behaviour:
- Reset (rst_in low, async): all outputs 0, x/y counters 0, right-error register 0, next-row error contributions discarded. The next accepted pixel is (0,0).
- Counters: x advances on each accepted pixel and wraps at H_PIXELS-1, then y increments. y wraps at V_PIXELS-1. Accepted pixels are the only frame-sync source.
- Threshold latch: on acceptance of pixel (0,0), the active threshold and threshold_active_out take threshold_in. Pixel (0,0) uses the new value. threshold_in changes at any other time are ignored until the next (0,0).
- Per accepted pixel at (x,y):
  - Compute v = pixel_in + err_right + err_below[x].
  - Use signed arithmetic, width ≥ 11 bits.
  - err_below[x] = 0 when y = 0.
  - err_right = 0 when x = 0.
- Saturate: vs = clamp(v, 0, 255).
- Quantise: out = (vs >= threshold) ? 1 : 0. Error e = vs - (out ? 255 : 0), range −255..255.
- Diffusion weights:
  - Each weight is (e*k) >>> 4, an arithmetic shift, i.e. floor.
  - Right neighbour: k=7.
  - Below-left: k=3.
  - Below: k=5.
  - Below-right: k=1.
- Edge rules:
  - Contributions falling outside x ∈ [0, H_PIXELS-1] are dropped.
  - Contributions from row V_PIXELS-1 are dropped.
  - No error crosses from x=H_PIXELS-1 to the next row's x=0 via the right path.
  - Row y+1 receives contributions only from row y; stale buffer contents from earlier rows or frames never accumulate.
- Line buffer: H_PIXELS entries of signed error, at least 10 bits wide. It must allow a read of entry x and a write of entries x-1..x+1 in the same accepted-pixel slot. Distributed RAM or registers are acceptable; a fixed latency is required.
- Latency: dithered_valid asserts exactly 1 cycle after each cycle with pixel_valid_in = 1, with dithered_pixel valid in that same cycle.
- Stalls: stalls (pixel_valid_in = 0) freeze all state. The output sequence is identical regardless of stall pattern.
- frame_done_out: pulses in the same cycle as the dithered_valid of pixel (H_PIXELS-1, V_PIXELS-1).
- Back-to-back: pixel_valid_in may be high every cycle indefinitely with no bubbles inserted.

Test Plan:
- All pixels 0, threshold 128 -> every dithered_pixel = 0. Exactly H*V dithered_valid strobes. One frame_done_out pulse, on the last strobe.
- All pixels 255, threshold 128 -> every dithered_pixel = 1. All errors stay 0.
- Row 0 of value 100, threshold 128:
  - x0: out 0, e = 100.
  - x1: v = 143, out 1, e = −112.
  - x2: v = 100 − 49 = 51, out 0.
  - Bench checks every pixel against a bit-exact reference model.
- threshold_in moves 128 -> 0 mid-frame -> remaining pixels of that frame still use 128. threshold_active_out becomes 0 coincident with acceptance of the next frame's (0,0).
- Same frame sent with random pixel_valid_in gaps versus back-to-back -> identical dithered_pixel sequences. Latency is 1 cycle on every strobe.
- Assert rst_in low mid-row (e.g. at x = 57, y = 3) -> outputs drop to 0 without a clock edge. After release, the first accepted pixel behaves as (0,0): threshold relatched, no residual error.
